ex_mem_skid: RTL
================

Name: ex_mem_skid

Overview:
- Pipeline boundary register between the execute stage and the memory-access stage.
- Captures the execute stage's write-back triple (destination address, write enable, result data) and presents it to the memory stage one cycle later.
- Two-entry skid buffer with a valid/ready handshake on both sides, so memory-stage back-pressure never drops an execute result and never creates a combinational ready path back into execute.
- Synchronous flush kills in-flight results.

Parameters:
- DATA_W, 32, result data width; matches the register data bus.
- ADDR_W, 5, destination register address width; matches the register address bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset (`ResetEnable` = 1).
- flush_i  input  1  synchronous kill of every buffered entry.
- ex_valid_i  input  1  execute stage presents a result this cycle.
- ex_ready_o  output  1  buffer can accept a result this cycle.
- ex_wd_i  input  ADDR_W  destination register address from execute.
- ex_wreg_i  input  1  register write enable from execute.
- ex_wdata_i  input  DATA_W  result data from execute.
- mem_valid_o  output  1  output entry is valid.
- mem_ready_i  input  1  memory stage consumes the output entry this cycle.
- mem_wd_o  output  ADDR_W  destination address to the memory stage.
- mem_wreg_o  output  1  write enable to the memory stage; forced to 0 whenever mem_valid_o = 0.
- mem_wdata_o  output  DATA_W  result data to the memory stage.

Behaviour:
- Storage: output register (OUT) and skid register (SKID), each holding {wd, wreg, wdata} plus a valid bit.
- Transfer definitions:
  - Accept: ex_valid_i & ex_ready_o.
  - Drain: mem_valid_o & mem_ready_i.
- State machine, encoded from the two valid bits:
  - EMPTY (OUT invalid, SKID invalid).
  - ONE (OUT valid, SKID invalid).
  - FULL (OUT valid, SKID valid).
- ex_ready_o = (state != FULL). It is a decode of registered state only; no combinational path from mem_ready_i.
- EMPTY:
  - Accept → OUT loads the input; go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - Accept & drain → OUT reloads from the input; stay in ONE (full throughput).
  - Accept & no drain → SKID loads the input; go to FULL.
  - Drain & no accept → go to EMPTY.
  - Neither → hold.
- FULL (no accept possible):
  - Drain → OUT loads from SKID; go to ONE.
  - No drain → hold everything.
- Latency and ordering:
  - Latency is 1 cycle from accept to mem_valid_o when the buffer is EMPTY or draining.
  - Results leave in the order accepted; no reordering and no duplication.
- Output hold: mem_wd_o and mem_wdata_o stay stable while mem_valid_o = 1 and mem_ready_i = 0.
- rst = 1 at a clock edge:
  - Go to EMPTY and clear all payload registers to zero.
  - Outputs after that edge: mem_valid_o = 0, mem_wreg_o = 0, mem_wd_o = 0, mem_wdata_o = `ZeroWord`, ex_ready_o = 1.
  - Reset mid-transfer discards both entries.
- flush_i = 1 at a clock edge:
  - Same effect as reset: go to EMPTY, payloads cleared.
  - An accept in the same cycle is discarded.
  - rst has priority over flush_i, which has priority over accept/drain.
- The ex_wd_i value is not interpreted; a result with address 0 and wreg = 1 is passed through unchanged.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- Defined: three extra output ports, driven combinationally from OUT, for operand bypass into the decode stage:
  - fwd_wreg_o = mem_valid_o & OUT.wreg
  - fwd_wd_o = OUT.wd
  - fwd_wdata_o = OUT.wdata
  - The SKID entry is not forwarded.
- Not defined: the ports are absent; the behaviour above is otherwise identical.

Decomposition:
- Shared package/include holds:
  - the state encoding (EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11);
  - the payload width constant, ADDR_W + 1 + DATA_W;
  - the existing `RegisterBus`, `RegisterAddressBus`, `ResetEnable` and `ZeroWord` definitions.
- One natural sub-module: wb_payload_reg, a payload register with load enable and synchronous clear, instantiated twice (OUT and SKID).

Test Plan:
- Reset: hold rst for 2 cycles with ex_valid_i = 1 → mem_valid_o = 0, mem_wreg_o = 0, mem_wdata_o = 0, ex_ready_o = 1; first accept after release appears 1 cycle later.
- Streaming: mem_ready_i = 1; send wd = 1..4 with wdata = 0x11111111 × wd → outputs arrive in order, one per cycle, 1-cycle latency, ex_ready_o stays 1.
- Back-pressure: mem_ready_i = 0; send wd = 3/0xA5A5A5A5, then wd = 7/0x5A5A5A5A → ex_ready_o = 0 after the second; output holds wd = 3. Raise mem_ready_i → wd = 3 then wd = 7 drain on consecutive cycles, then ex_ready_o = 1.
- Flush in FULL while ex_valid_i = 1 → next cycle EMPTY, mem_valid_o = 0, the third result is discarded, ex_ready_o = 1.
- Bubble gating: ex_valid_i = 1 with ex_wreg_i = 1 for one cycle, then idle with mem_ready_i = 1 → mem_wreg_o is 1 for exactly one cycle and 0 while mem_valid_o = 0.
- EX_MEM_FWD_EN defined: OUT holds wd = 9/0xDEADBEEF with wreg = 1 → fwd_wreg_o = 1, fwd_wd_o = 9, fwd_wdata_o = 0xDEADBEEF; after drain to EMPTY, fwd_wreg_o = 0.

Source files
------------

// File: rtl/ex_mem_skid_pkg.sv
// Shared definitions for the EX/MEM skid boundary: bus widths, reset polarity,
// state encoding and the write-back payload width helper.
package ex_mem_skid_pkg;

  localparam int unsigned RegisterBus        = 32;
  localparam int unsigned RegisterAddressBus = 5;
  localparam logic        ResetEnable        = 1'b1;
  localparam logic [RegisterBus-1:0] ZeroWord = '0;

  // Encoding is {skid valid, out valid}.
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b01;
  localparam logic [1:0] StFull  = 2'b11;

  function automatic int unsigned payload_w(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + 1 + data_w;
  endfunction

endpackage

// File: rtl/wb_payload_reg.sv
// Write-back payload register: synchronous clear (priority) and load enable.
module wb_payload_reg #(
  parameter int unsigned       Width  = 38,
  parameter logic [Width-1:0]  ClrVal = '0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= ClrVal;
    end else if (ld_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM two-entry skid buffer with registered ready and synchronous flush.
// Optional decode-stage bypass ports are enabled by defining EX_MEM_FWD_EN.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int unsigned DATA_W = RegisterBus,
  parameter int unsigned ADDR_W = RegisterAddressBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_wd_o,
  output logic              mem_wreg_o,
`ifdef EX_MEM_FWD_EN
  output logic              fwd_wreg_o,
  output logic [ADDR_W-1:0] fwd_wd_o,
  output logic [DATA_W-1:0] fwd_wdata_o,
`endif
  output logic [DATA_W-1:0] mem_wdata_o
);

  localparam int unsigned      PW     = payload_w(ADDR_W, DATA_W);
  localparam logic [PW-1:0]    ClrVal = {{ADDR_W{1'b0}}, 1'b0, DATA_W'(ZeroWord)};

  logic [1:0]    state_q, state_d;
  logic          clr, accept, drain;
  logic          out_ld, out_from_skid, skid_ld;
  logic [PW-1:0] in_pld, out_d, out_q, skid_q;

  assign clr    = (rst == ResetEnable) | flush_i;
  assign accept = ex_valid_i & ex_ready_o;
  assign drain  = mem_valid_o & mem_ready_i;
  assign in_pld = {ex_wd_i, ex_wreg_i, ex_wdata_i};

  always_comb begin
    state_d       = state_q;
    out_ld        = 1'b0;
    out_from_skid = 1'b0;
    skid_ld       = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          out_ld  = 1'b1;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          out_ld = 1'b1;
        end else if (accept) begin
          skid_ld = 1'b1;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          out_ld        = 1'b1;
          out_from_skid = 1'b1;
          state_d       = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_d = out_from_skid ? skid_q : in_pld;

  wb_payload_reg #(
    .Width  (PW),
    .ClrVal (ClrVal)
  ) u_out (
    .clk_i (clk),
    .clr_i (clr),
    .ld_i  (out_ld),
    .d_i   (out_d),
    .q_o   (out_q)
  );

  wb_payload_reg #(
    .Width  (PW),
    .ClrVal (ClrVal)
  ) u_skid (
    .clk_i (clk),
    .clr_i (clr),
    .ld_i  (skid_ld),
    .d_i   (in_pld),
    .q_o   (skid_q)
  );

  // Ready is a pure decode of registered state: no path from mem_ready_i.
  assign ex_ready_o  = (state_q != StFull);
  assign mem_valid_o = state_q[0];
  assign mem_wd_o    = out_q[PW-1 -: ADDR_W];
  assign mem_wreg_o  = mem_valid_o & out_q[DATA_W];
  assign mem_wdata_o = out_q[DATA_W-1:0];

`ifdef EX_MEM_FWD_EN
  assign fwd_wreg_o  = mem_valid_o & out_q[DATA_W];
  assign fwd_wd_o    = out_q[PW-1 -: ADDR_W];
  assign fwd_wdata_o = out_q[DATA_W-1:0];
`endif

endmodule
